// File: rtl/blk_com_fifo_param.sv
// Synchronous FIFO with registered status flags and sticky overflow/underflow.
// Define COM_FIFO_FWFT_EN for first-word-fall-through output.
module blk_com_fifo_param #(
    parameter int DATA_W    = 36,
    parameter int ADDR_W    = 10,
    parameter int AFULL_TH  = 1000,
    parameter int AEMPTY_TH = 8
) (
    input  logic              I_fifo_clk,
    input  logic              I_fifo_rst,
    input  logic [DATA_W-1:0] I_fifo_din,
    input  logic              I_fifo_wr,
    input  logic              I_fifo_rd,
    input  logic              I_fifo_err_clr,
    output logic [DATA_W-1:0] O_fifo_dout,
    output logic              O_fifo_empty,
    output logic              O_fifo_full,
    output logic              O_fifo_afull,
    output logic              O_fifo_aempty,
    output logic [ADDR_W:0]   O_fifo_usedw,
    output logic              O_fifo_ovf,
    output logic              O_fifo_udf
);

    localparam logic [ADDR_W:0] L_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] L_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_cnt;
    logic [DATA_W-1:0] r_dout;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_ovf;
    logic              r_udf;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W:0]   w_cnt_nxt;

    // Acceptance is judged against registered flags; reset masks both.
    assign w_wr_acc = I_fifo_wr & ~r_full  & ~I_fifo_rst;
    assign w_rd_acc = I_fifo_rd & ~r_empty & ~I_fifo_rst;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_wr_acc && !w_rd_acc) begin
            w_cnt_nxt = r_cnt + L_ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_cnt_nxt = r_cnt - L_ONE;
        end
    end

    always_ff @(posedge I_fifo_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= I_fifo_din;
        end
    end

    always_ff @(posedge I_fifo_clk) begin
        if (I_fifo_rst) begin
            r_wptr   <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            r_cnt    <= w_cnt_nxt;
            r_full   <= (w_cnt_nxt == L_DEPTH);
            r_afull  <= (int'(w_cnt_nxt) >= AFULL_TH);
            r_aempty <= (int'(w_cnt_nxt) <= AEMPTY_TH);
        end
    end

`ifdef COM_FIFO_FWFT_EN
    logic [ADDR_W:0] r_rcnt;
    logic            w_load;

    // Words still in RAM; the output register is refilled whenever it frees up.
    assign w_load = (r_rcnt != '0) && (r_empty || w_rd_acc);

    always_ff @(posedge I_fifo_clk) begin
        if (I_fifo_rst) begin
            r_rptr  <= '0;
            r_rcnt  <= '0;
            r_empty <= 1'b1;
            r_dout  <= '0;
        end else begin
            if (w_load) begin
                r_dout <= r_mem[r_rptr];
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_wr_acc && !w_load) begin
                r_rcnt <= r_rcnt + L_ONE;
            end else if (!w_wr_acc && w_load) begin
                r_rcnt <= r_rcnt - L_ONE;
            end
            r_empty <= ~(w_load | (~r_empty & ~w_rd_acc));
        end
    end
`else
    always_ff @(posedge I_fifo_clk) begin
        if (I_fifo_rst) begin
            r_rptr  <= '0;
            r_empty <= 1'b1;
            r_dout  <= '0;
        end else begin
            if (w_rd_acc) begin
                r_dout <= r_mem[r_rptr];
                r_rptr <= r_rptr + 1'b1;
            end
            r_empty <= (w_cnt_nxt == '0);
        end
    end
`endif

    // Sticky errors: a new event in the clear cycle keeps the flag set.
    always_ff @(posedge I_fifo_clk) begin
        if (I_fifo_rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (I_fifo_wr && r_full) begin
                r_ovf <= 1'b1;
            end else if (I_fifo_err_clr) begin
                r_ovf <= 1'b0;
            end
            if (I_fifo_rd && r_empty) begin
                r_udf <= 1'b1;
            end else if (I_fifo_err_clr) begin
                r_udf <= 1'b0;
            end
        end
    end

    assign O_fifo_dout   = r_dout;
    assign O_fifo_empty  = r_empty;
    assign O_fifo_full   = r_full;
    assign O_fifo_afull  = r_afull;
    assign O_fifo_aempty = r_aempty;
    assign O_fifo_usedw  = r_cnt;
    assign O_fifo_ovf    = r_ovf;
    assign O_fifo_udf    = r_udf;

endmodule

// File: tb/tb_blk_com_fifo_param.sv
// Scoreboard bench for blk_com_fifo_param against a queue-based model.
// Directed scenarios followed by randomized traffic.
module tb_blk_com_fifo_param;

    localparam int DW = 36;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] dout;
    logic          empty, full, afull, aempty, ovf, udf;
    logic [AW:0]   usedw;

    int n_pass = 0;
    int n_total = 0;

    blk_com_fifo_param #(
        .DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AF), .AEMPTY_TH(AE)
    ) dut (
        .I_fifo_clk(clk),
        .I_fifo_rst(rst),
        .I_fifo_din(din),
        .I_fifo_wr(wr),
        .I_fifo_rd(rd),
        .I_fifo_err_clr(clr),
        .O_fifo_dout(dout),
        .O_fifo_empty(empty),
        .O_fifo_full(full),
        .O_fifo_afull(afull),
        .O_fifo_aempty(aempty),
        .O_fifo_usedw(usedw),
        .O_fifo_ovf(ovf),
        .O_fifo_udf(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [DW-1:0] d,
                         input logic c, input logic rs);
        @(negedge clk);
        wr = w;
        rd = r;
        din = d;
        clr = c;
        rst = rs;
    endtask

    // Reference model: contents as a queue, expected read data as a scoreboard.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] sb[$];
    bit            m_ovf = 0;
    bit            m_udf = 0;
    bit            m_live = 0;

`ifndef COM_FIFO_FWFT_EN
    always @(posedge clk) begin
        bit m_full, m_empty, wa, ra;
        if (rst) begin
            mq.delete();
            m_ovf = 0;
            m_udf = 0;
            sb.push_back('0);
        end else begin
            m_full = (mq.size() == DEPTH);
            m_empty = (mq.size() == 0);
            wa = wr && !m_full;
            ra = rd && !m_empty;
            if (wr && m_full) m_ovf = 1;
            else if (clr) m_ovf = 0;
            if (rd && m_empty) m_udf = 1;
            else if (clr) m_udf = 0;
            if (ra) sb.push_back(mq.pop_front());
            if (wa) mq.push_back(din);
        end
        m_live = 1;
    end

    // Monitor: status every cycle, data when a read result is due.
    always @(negedge clk) begin
        logic [63:0] e_st, a_st;
        int n;
        if (m_live) begin
            n = mq.size();
            e_st = {48'd0, 5'(n), (n == DEPTH), (n == 0), (n >= AF),
                    (n <= AE), m_ovf, m_udf, 4'd0};
            a_st = {48'd0, usedw, full, empty, afull, aempty, ovf, udf, 4'd0};
            chk("status", a_st, e_st);
            if (sb.size() > 0) begin
                chk("dout", 64'(dout), 64'(sb.pop_front()));
            end
        end
    end
`endif

    initial begin
        drive(0, 0, '0, 0, 1);
        drive(0, 0, '0, 0, 1);
`ifdef COM_FIFO_FWFT_EN
        drive(1, 0, 36'h123, 0, 0);
        drive(0, 0, '0, 0, 0);
        chk("fwft_empty_1cyc", 64'(empty), 64'd1);
        drive(0, 0, '0, 0, 0);
        chk("fwft_dout_2cyc", 64'(dout), 64'h123);
        chk("fwft_empty_2cyc", 64'(empty), 64'd0);
        chk("fwft_usedw", 64'(usedw), 64'd1);
        drive(0, 1, '0, 0, 0);
        drive(0, 0, '0, 0, 0);
        chk("fwft_empty_after_rd", 64'(empty), 64'd1);
        chk("fwft_usedw_after_rd", 64'(usedw), 64'd0);
        for (int i = 0; i < 4; i++) drive(1, 0, 36'(i + 'h50), 0, 0);
        drive(0, 0, '0, 0, 0);
        drive(0, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("fwft_seq", 64'(dout), 64'(i + 'h50));
            drive(0, 1, '0, 0, 0);
        end
        drive(0, 0, '0, 0, 0);
        chk("fwft_drained", 64'(empty), 64'd1);
`else
        // Fill to full.
        for (int i = 1; i <= 16; i++) drive(1, 0, 36'(i), 0, 0);
        // Overflow attempt.
        drive(1, 0, 36'hF_FFFF_FFFF, 0, 0);
        // Drain.
        for (int i = 0; i < 16; i++) drive(0, 1, '0, 0, 0);
        drive(0, 0, '0, 0, 0);
        // Underflow, clear racing a second underflow, then plain clear.
        drive(0, 1, '0, 0, 0);
        drive(0, 1, '0, 1, 0);
        drive(0, 0, '0, 1, 0);
        drive(0, 0, '0, 0, 0);
        // Steady state at 5 words with pointer wrap.
        for (int i = 0; i < 5; i++) drive(1, 0, 36'($urandom), 0, 0);
        for (int i = 0; i < 40; i++) drive(1, 1, 36'($urandom), 0, 0);
        drive(0, 0, '0, 1, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, '0, 0, 0);
        // Reset mid-operation with a write pending.
        for (int i = 0; i < 8; i++) drive(1, 0, 36'(i + 'h100), 0, 0);
        drive(1, 0, 36'h777, 0, 1);
        drive(1, 0, 36'hA5, 0, 0);
        drive(0, 1, '0, 0, 0);
        drive(0, 0, '0, 0, 0);
        // Random traffic: fill-biased then drain-biased.
        for (int i = 0; i < 400; i++) begin
            bit w, r, c, s;
            w = ($urandom_range(0, 99) < ((i < 200) ? 75 : 30));
            r = ($urandom_range(0, 99) < ((i < 200) ? 30 : 75));
            c = ($urandom_range(0, 99) < 5);
            s = ($urandom_range(0, 99) < 2);
            drive(w, r, 36'($urandom) ^ {4'($urandom), 32'd0}, c, s);
        end
        drive(0, 0, '0, 0, 0);
        drive(0, 0, '0, 0, 0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
`endif
        drive(0, 0, '0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
